// File: rtl/boothmul_arbiter_pkg.sv
// boothmul_arbiter_pkg: shared state encoding, default widths and index helper for the multiplier arbiter.
package boothmul_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RELEASE = 2'd2} state_t;
    localparam int DEF_A1_LEN = 32;
    localparam int DEF_A2_LEN = 32;
    localparam int OUT_LEN = DEF_A1_LEN + DEF_A2_LEN;
    // Modulo for a sum that is known to be below 2*n.
    function automatic int wrap_idx(input int k, input int n);
        return k >= n ? k - n : k;
    endfunction
endpackage

// File: rtl/boothmul_arbiter_rr_pick.sv
// boothmul_arbiter_rr_pick: first set request scanning upward from ptr_i with wrap-around.
module boothmul_arbiter_rr_pick
    import boothmul_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_o
);
    logic [IDX_W-1:0] k;
    // Scan from the far end down so the candidate closest to ptr_i is written last.
    always_comb begin
        winner_o = '0;
        k = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = IDX_W'(wrap_idx(int'(ptr_i) + i, N_REQ));
            winner_o = req_i[k] ? k : winner_o;
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/boothmul_arbiter.sv
// boothmul_arbiter: round-robin sharing of one boothmul sequential multiplier among N_REQ requesters.
module boothmul_arbiter
    import boothmul_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int IDX_W  = 2,
    parameter int A1_LEN = 32,
    parameter int A2_LEN = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*A1_LEN-1:0]    a1_in,
    input  logic [N_REQ*A2_LEN-1:0]    a2_in,
    output logic [N_REQ-1:0]           done,
    output logic [A1_LEN+A2_LEN-1:0]   result,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       busy,
    output logic                       mul_arm,
    output logic [A1_LEN-1:0]          mul_a1,
    output logic [A2_LEN-1:0]          mul_a2,
    input  logic [A1_LEN+A2_LEN-1:0]   mul_outn,
    input  logic                       mul_fin
);
    localparam int P_LEN = A1_LEN + A2_LEN;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [P_LEN-1:0]   result_q, result_d;
    logic [IDX_W-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d, winner;
    logic               busy_q, busy_d, arm_q, arm_d, any_req;
    logic [A1_LEN-1:0]  a1_q, a1_d;
    logic [A2_LEN-1:0]  a2_q, a2_d;

    boothmul_arbiter_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        result_d = result_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        busy_d   = busy_q;
        arm_d    = arm_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        case (state_q)
            IDLE: if (any_req) begin
                grant_d = winner;
                a1_d    = a1_in[int'(winner)*A1_LEN +: A1_LEN];
                a2_d    = a2_in[int'(winner)*A2_LEN +: A2_LEN];
                arm_d   = 1'b1;
                busy_d  = 1'b1;
                state_d = RUN;
            end
            // Completion is keyed on fin alone, so any multiplier latency works.
            RUN: if (mul_fin) begin
                result_d = mul_outn;
                done_d   = N_REQ'(1) << grant_q;
                arm_d    = 1'b0;
                rr_ptr_d = grant_q == IDX_W'(N_REQ - 1) ? '0 : grant_q + 1'b1;
                state_d  = RELEASE;
            end
            RELEASE: begin
                done_d  = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            done_q   <= '0;
            result_q <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
            arm_q    <= 1'b0;
            a1_q     <= '0;
            a2_q     <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            arm_q    <= arm_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
        end
    end

    assign done      = done_q;
    assign result    = result_q;
    assign grant_idx = grant_q;
    assign busy      = busy_q;
    assign mul_arm   = arm_q;
    assign mul_a1    = a1_q;
    assign mul_a2    = a2_q;
endmodule

// File: tb/tb_boothmul_arbiter.sv
// tb_boothmul_arbiter: directed vectors against a cycle-level boothmul stand-in.
module tb_boothmul_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   a1_in = '0;
    logic [N*W-1:0]   a2_in = '0;
    logic [N-1:0]     done;
    logic [2*W-1:0]   result;
    logic [1:0]       grant_idx;
    logic             busy, mul_arm;
    logic [W-1:0]     mul_a1, mul_a2;
    logic [2*W-1:0]   mul_outn = '0;
    logic             mul_fin = 1'b0;
    int               m_cnt = 0;
    int               checks = 0;
    int               errors = 0;

    boothmul_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a1_in(a1_in), .a2_in(a2_in),
        .done(done), .result(result), .grant_idx(grant_idx), .busy(busy),
        .mul_arm(mul_arm), .mul_a1(mul_a1), .mul_a2(mul_a2),
        .mul_outn(mul_outn), .mul_fin(mul_fin)
    );

    always #5 clk = ~clk;

    // boothmul stand-in: fin rises on the (W+2)th edge that sees arm high, cleared when arm drops.
    always @(posedge clk) begin
        if (!mul_arm) begin
            m_cnt <= 0;
            mul_fin <= 1'b0;
        end else if (!mul_fin) begin
            if (m_cnt == W + 1) begin
                mul_fin <= 1'b1;
                mul_outn <= $signed(mul_a1) * $signed(mul_a2);
            end else
                m_cnt <= m_cnt + 1;
        end
    end

    typedef struct {
        int           idx;
        logic [31:0]  a1;
        logic [31:0]  a2;
        logic [63:0]  exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts edges until done is seen; called at a negedge, so a single request sees done on edge 36.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done == '0 && n < 200);
        if (done == '0) begin
            errors++;
            $display("FAIL timeout: no done within %0d edges", n);
        end
    endtask

    task automatic set_ops(input int k, input logic [31:0] a1, input logic [31:0] a2);
        a1_in[k*W +: W] = a1;
        a2_in[k*W +: W] = a2;
    endtask

    vec_t vecs[7];
    int   n;
    logic [63:0] exp_c[5];
    logic [3:0]  exp_d[5];

    initial begin
        vecs[0] = '{0, 32'd3,          32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[1] = '{1, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[2] = '{2, 32'hFFFF_FFFF,  32'd1,         64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{3, 32'd7,          32'd6,         64'd42};
        vecs[4] = '{0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[5] = '{1, 32'h7FFF_FFFF,  32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[6] = '{2, 32'd0,          32'h1234_5678, 64'd0};

        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_arm", {63'd0, mul_arm}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_done", {60'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            set_ops(vecs[i].idx, vecs[i].a1, vecs[i].a2);
            req = 4'b1 << vecs[i].idx;
            wait_done(n);
            chk($sformatf("vec%0d_latency", i), 64'(n), 64'd36);
            chk($sformatf("vec%0d_done", i), {60'd0, done}, {60'd0, 4'b1 << vecs[i].idx});
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
            req = '0;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_busy_low", i), {63'd0, busy}, 64'd0);
            chk($sformatf("vec%0d_done_low", i), {60'd0, done}, 64'd0);
            @(negedge clk);
        end

        // Requester 2 was served last, so the pointer sits at 3 and wraps to 0.
        set_ops(0, 32'd11, 32'd13);
        set_ops(2, 32'hFFFF_FFFE, 32'd9);
        req = 4'b0101;
        wait_done(n);
        chk("rot_first_done", {60'd0, done}, 64'b0001);
        chk("rot_first_result", result, 64'd143);
        wait_done(n);
        chk("rot_second_done", {60'd0, done}, 64'b0100);
        chk("rot_second_result", result, 64'hFFFF_FFFF_FFFF_FFEE);
        req = '0;
        repeat (2) @(negedge clk);

        set_ops(1, 32'd100, 32'hFFFF_FFFD);
        req = 4'b0010;
        repeat (11) @(negedge clk);
        req = '0;
        set_ops(1, 32'd999, 32'd5);
        wait_done(n);
        chk("drop_done", {60'd0, done}, 64'b0010);
        chk("drop_result", result, 64'hFFFF_FFFF_FFFF_FED4);
        repeat (2) @(negedge clk);

        set_ops(1, 32'd6, 32'd7);
        req = 4'b0010;
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_done", {60'd0, done}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_arm", {63'd0, mul_arm}, 64'd0);
        chk("arst_result", result, 64'd0);
        chk("arst_grant", {62'd0, grant_idx}, 64'd0);
        chk("arst_a1", {32'd0, mul_a1}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(n);
        chk("arst_fresh_latency", 64'(n), 64'd36);
        chk("arst_fresh_done", {60'd0, done}, 64'b0010);
        chk("arst_fresh_result", result, 64'd42);
        req = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < N; k++) set_ops(k, 32'(k + 2), -32'(k + 10));
        exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_c = '{-64'sd20, -64'sd33, -64'sd48, -64'sd65, -64'sd20};
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_done(n);
            chk($sformatf("rr%0d_spacing", j), 64'(n), j == 0 ? 64'd36 : 64'd37);
            chk($sformatf("rr%0d_done", j), {60'd0, done}, {60'd0, exp_d[j]});
            chk($sformatf("rr%0d_result", j), result, exp_c[j]);
            chk($sformatf("rr%0d_arm_low", j), {63'd0, mul_arm}, 64'd0);
        end
        req = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
